// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of a
// slow cs/ack word RAM, with saturating read hit/miss counters.
module dcache #(
  parameter int          RAM_ADDR_WIDTH = 5,
  parameter int          INDEX_WIDTH    = 3,
  parameter logic [31:0] PARK_ADDR      = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_ack,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
  output logic [1:0]  dbg_state
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = RAM_ADDR_WIDTH - INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, PARK} state_e;

  state_e                 state_q;
  logic [LINES-1:0]       valid_q;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [31:0]            data_q [LINES];
  logic                   mem_cs_q, mem_we_q, park_rd_q;
  logic [31:0]            mem_addr_q, mem_din_q, resp_q;
  logic [15:0]            hit_q, miss_q;

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_W-1:0]       tag;
  logic                   cacheable, line_hit, rd_hit;

  assign idx       = cpu_addr[INDEX_WIDTH-1:0];
  assign tag       = cpu_addr[RAM_ADDR_WIDTH-1:INDEX_WIDTH];
  assign cacheable = (cpu_addr[31:RAM_ADDR_WIDTH] == '0);
  assign line_hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign rd_hit    = cpu_cs && !cpu_we && cacheable && line_hit;

  // RAM handshake: mem_cs/mem_addr/mem_we/mem_din are held constant until
  // mem_ack is sampled high; then the address parks for one cycle so the RAM
  // sees an address change and drops ack before the next access.
  always_comb begin
    cpu_stall = 1'b0;
    cpu_dout  = '0;
    case (state_q)
      IDLE: begin
        cpu_stall = cpu_cs && cacheable && !rd_hit;
        if (rd_hit) cpu_dout = data_q[idx];
      end
      FILL, WRITE: cpu_stall = 1'b1;
      PARK: if (park_rd_q) cpu_dout = resp_q;
      default: ;
    endcase
    if (!rst) begin
      cpu_stall = 1'b0;
      cpu_dout  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= PARK_ADDR;
      mem_din_q  <= '0;
      resp_q     <= '0;
      park_rd_q  <= 1'b0;
      hit_q      <= '0;
      miss_q     <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_cs && cacheable) begin
            if (!cpu_we && line_hit) begin
              if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
            end else begin
              if (!cpu_we && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
              state_q    <= cpu_we ? WRITE : FILL;
              mem_cs_q   <= 1'b1;
              mem_we_q   <= cpu_we;
              mem_addr_q <= cpu_addr;
              mem_din_q  <= cpu_we ? cpu_din : 32'd0;
            end
          end
        end
        FILL, WRITE: begin
          if (mem_ack) begin
            if (state_q == FILL) begin
              valid_q[idx] <= 1'b1;
              tag_q[idx]   <= tag;
              data_q[idx]  <= mem_dout;
              resp_q       <= mem_dout;
            end else if (line_hit) begin
              data_q[idx]  <= cpu_din;
            end
            park_rd_q  <= (state_q == FILL);
            state_q    <= PARK;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= PARK_ADDR;
            mem_din_q  <= '0;
          end
        end
        PARK:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign hit_cnt   = hit_q;
  assign miss_cnt  = miss_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: a slow stable-address RAM model, a transaction-level cache
// model driving per-cycle expectations, and literal checks on key results.
module tb_dcache;
  localparam logic [31:0] PARK = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cs, cpu_we;
  logic [31:0] cpu_addr, cpu_din, cpu_dout;
  logic        cpu_stall;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_ack;
  logic [15:0] hit_cnt, miss_cnt;
  logic [1:0]  dbg_state;

  dcache dut (
    .clk(clk), .rst(rst),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // RAM: ack rises on the 9th negedge after mem_addr changes, holds while stable.
  logic [31:0] ram [32];
  logic [31:0] ram_last = 32'h0;
  int          ram_cnt  = 0;
  initial mem_ack = 1'b0;
  always @(negedge clk) begin
    if (mem_addr !== ram_last) begin
      ram_last = mem_addr;
      ram_cnt  = 1;
    end else if (ram_cnt < 9) begin
      ram_cnt++;
    end
    mem_ack = (ram_cnt >= 9);
  end
  assign mem_dout = ram[mem_addr[4:0]];
  always @(posedge clk) if (mem_cs && mem_we && mem_ack) ram[mem_addr[4:0]] = mem_din;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cache model
  logic        m_valid [8];
  logic [1:0]  m_tag   [8];
  logic [31:0] m_data  [8];

  logic        chk_en = 1'b0;
  logic        e_stall, e_mcs, e_mwe, e_din_chk;
  logic [31:0] e_dout, e_maddr, e_mdin;
  logic [15:0] e_hit, e_miss;
  int          obs_stall = 0;
  logic [31:0] last_dout;

  always @(negedge clk) begin
    if (chk_en) begin
      check("cpu_stall", {31'd0, cpu_stall}, {31'd0, e_stall});
      check("cpu_dout",  cpu_dout, e_dout);
      check("mem_cs",    {31'd0, mem_cs}, {31'd0, e_mcs});
      check("mem_we",    {31'd0, mem_we}, {31'd0, e_mwe});
      check("mem_addr",  mem_addr, e_maddr);
      if (e_din_chk) check("mem_din", mem_din, e_mdin);
      check("hit_cnt",   {16'd0, hit_cnt}, {16'd0, e_hit});
      check("miss_cnt",  {16'd0, miss_cnt}, {16'd0, e_miss});
    end
    if (cpu_stall) obs_stall++;
  end

  task automatic set_mem_idle();
    e_mcs = 1'b0; e_mwe = 1'b0; e_maddr = PARK; e_din_chk = 1'b0; e_mdin = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
    end
    e_hit = '0; e_miss = '0;
    e_stall = 1'b0; e_dout = '0;
    set_mem_idle();
  endtask

  // One CPU access; a stalling access takes a request cycle, 9 RAM cycles, then PARK.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] din);
    logic        cacheable, hit;
    int          idx;
    logic [31:0] rdata;
    cacheable = (addr[31:5] == 27'd0);
    idx       = int'(addr[2:0]);
    hit       = cacheable && m_valid[idx] && (m_tag[idx] == addr[4:3]);
    rdata     = ram[addr[4:0]];
    @(posedge clk); #1;
    cpu_cs = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
    obs_stall = 0;
    set_mem_idle();
    if (!cacheable || (!we && hit)) begin
      e_stall = 1'b0;
      e_dout  = (cacheable && !we) ? m_data[idx] : 32'd0;
      @(negedge clk); last_dout = cpu_dout;
      @(posedge clk); #1;
      if (cacheable) e_hit++;
    end else begin
      e_stall = 1'b1; e_dout = '0;
      @(posedge clk); #1;
      if (!we) e_miss++;
      for (int k = 0; k < 9; k++) begin
        e_mcs = 1'b1; e_mwe = we; e_maddr = addr;
        e_mdin = din; e_din_chk = we;
        @(posedge clk); #1;
      end
      set_mem_idle();
      e_stall = 1'b0;
      e_dout  = we ? 32'd0 : rdata;
      @(negedge clk); last_dout = cpu_dout;
      @(posedge clk); #1;
      if (!we) begin
        m_valid[idx] = 1'b1; m_tag[idx] = addr[4:3]; m_data[idx] = rdata;
      end else if (hit) begin
        m_data[idx] = din;
      end
    end
    cpu_cs = 1'b0; cpu_we = 1'b0;
    e_stall = 1'b0; e_dout = '0;
  endtask

  initial begin
    rst = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    last_dout = '0;
    for (int i = 0; i < 32; i++) ram[i] = 32'hA000_0000 + 32'(i);
    ram[3] = 32'hDEAD_BEEF;
    model_reset();
    #12;
    check("rst_mem_cs",   {31'd0, mem_cs}, 32'd0);
    check("rst_mem_addr", mem_addr, PARK);
    check("rst_mem_din",  mem_din, 32'd0);
    check("rst_stall",    {31'd0, cpu_stall}, 32'd0);
    check("rst_cnts",     {hit_cnt, miss_cnt}, 32'd0);
    #10 rst = 1'b1;
    chk_en = 1'b1;

    access(1'b0, 32'd3, 32'd0);
    check("miss3_stall", 32'(obs_stall), 32'd10);
    check("miss3_dout",  last_dout, 32'hDEAD_BEEF);
    check("miss3_cnt",   {16'd0, miss_cnt}, 32'd1);
    access(1'b0, 32'd3, 32'd0);
    check("hit3_stall", 32'(obs_stall), 32'd0);
    check("hit3_dout",  last_dout, 32'hDEAD_BEEF);
    check("hit3_cnt",   {16'd0, hit_cnt}, 32'd1);

    access(1'b1, 32'd3, 32'h1234_5678);
    check("wr3_stall", 32'(obs_stall), 32'd10);
    check("wr3_ram",   ram[3], 32'h1234_5678);
    access(1'b0, 32'd3, 32'd0);
    check("rehit3_dout", last_dout, 32'h1234_5678);
    check("rehit3_cnt",  {16'd0, hit_cnt}, 32'd2);

    access(1'b1, 32'd12, 32'hCAFE_F00D);
    check("wr12_ram", ram[12], 32'hCAFE_F00D);
    access(1'b0, 32'd12, 32'd0);
    check("rd12_stall", 32'(obs_stall), 32'd10);
    check("rd12_dout",  last_dout, 32'hCAFE_F00D);
    check("rd12_miss",  {16'd0, miss_cnt}, 32'd2);

    access(1'b0, 32'd2, 32'd0);
    access(1'b0, 32'd10, 32'd0);
    check("rd10_dout", last_dout, 32'hA000_000A);
    access(1'b0, 32'd2, 32'd0);
    check("rd2_again_stall", 32'(obs_stall), 32'd10);
    check("rd2_again_dout",  last_dout, 32'hA000_0002);
    check("conflict_miss",   {16'd0, miss_cnt}, 32'd5);

    access(1'b0, 32'h0000_0040, 32'd0);
    check("unc_rd_stall", 32'(obs_stall), 32'd0);
    check("unc_rd_dout",  last_dout, 32'd0);
    access(1'b1, 32'h0000_0044, 32'h5555_AAAA);
    check("unc_wr_stall", 32'(obs_stall), 32'd0);
    check("unc_cnts",     {hit_cnt, miss_cnt}, {16'd2, 16'd5});

    // Abandon a fill in its 4th cycle with an asynchronous reset.
    @(posedge clk); #1;
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd5;
    e_stall = 1'b1; e_dout = '0; set_mem_idle();
    @(posedge clk); #1;
    e_miss++;
    e_mcs = 1'b1; e_mwe = 1'b0; e_maddr = 32'd5;
    repeat (3) begin @(posedge clk); #1; end
    #2 chk_en = 1'b0; rst = 1'b0;
    #1;
    check("arst_mem_cs",   {31'd0, mem_cs}, 32'd0);
    check("arst_mem_we",   {31'd0, mem_we}, 32'd0);
    check("arst_mem_addr", mem_addr, PARK);
    check("arst_mem_din",  mem_din, 32'd0);
    check("arst_stall",    {31'd0, cpu_stall}, 32'd0);
    check("arst_dout",     cpu_dout, 32'd0);
    check("arst_cnts",     {hit_cnt, miss_cnt}, 32'd0);
    cpu_cs = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    chk_en = 1'b1;

    access(1'b0, 32'd5, 32'd0);
    check("post_rst_stall", 32'(obs_stall), 32'd10);
    check("post_rst_dout",  last_dout, 32'hA000_0005);
    check("post_rst_miss",  {16'd0, miss_cnt}, 32'd1);
    access(1'b0, 32'd5, 32'd0);
    check("post_rst_hit",   {16'd0, hit_cnt}, 32'd1);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-through, no-write-allocate data cache between the CPU MEM stage and the slow `data_ram` word memory. Read hits return data in the request cycle with no stall. Read misses and all writes run the `data_ram` cs/ack handshake while holding the CPU stalled. Two saturating counters export hit and miss statistics.

## Interface
Parameters:
- `RAM_ADDR_WIDTH`, 5: word-address bits backed by RAM. Addresses with `addr[31:RAM_ADDR_WIDTH]!=0` are uncacheable and out of range.
- `INDEX_WIDTH`, 3: number of lines is `1<<INDEX_WIDTH`, one 32-bit word per line. Must be less than `RAM_ADDR_WIDTH`.
- `PARK_ADDR`, 32'hFFFF_FFFF: idle value driven on `mem_addr`.

Ports:
- `clk` in 1: the single clock; all state changes on posedge.
- `rst` in 1: reset is asynchronous and active-low.
- `cpu_cs` in 1: CPU access request.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 32: word address.
- `cpu_din` in 32: write data.
- `cpu_dout` out 32: read data.
- `cpu_stall` out 1: CPU must hold its request while this is high.
- `mem_cs` out 1: RAM access request.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out 32: RAM address.
- `mem_din` out 32: RAM write data.
- `mem_dout` in 32: RAM read data.
- `mem_ack` in 1: RAM completion. Stays high while `mem_addr` is held.
- `hit_cnt` out 16: saturating count of read hits.
- `miss_cnt` out 16: saturating count of read misses.

## Operation
- Address split: index = `cpu_addr[INDEX_WIDTH-1:0]`, tag = `cpu_addr[RAM_ADDR_WIDTH-1:INDEX_WIDTH]`.
- Each line holds a valid bit, a tag and a data word.
- FSM states are IDLE, FILL, WRITE and PARK.
- IDLE:
  - `mem_cs=0`, `mem_we=0`, `mem_addr=PARK_ADDR`.
  - Read hit (`cpu_cs & ~cpu_we`, valid, tag match): `cpu_dout` = line data, `cpu_stall=0`, `hit_cnt` increments. State stays IDLE.
  - Uncacheable access: `cpu_dout=0`, `cpu_stall=0`. No RAM access, no counter change, no line change.
  - Read miss: `cpu_stall=1`, `miss_cnt` increments, go to FILL.
  - Write: `cpu_stall=1`, go to WRITE.
  - `cpu_cs=0`: `cpu_stall=0`, `cpu_dout=0`.
- FILL:
  - `mem_cs=1`, `mem_we=0`, `mem_addr=cpu_addr` held stable, `cpu_stall=1`.
  - On `mem_ack`: line ← {valid=1, tag, `mem_dout`}, and `mem_dout` is latched into a response register. Go to PARK.
- WRITE:
  - `mem_cs=1`, `mem_we=1`, `mem_addr=cpu_addr`, `mem_din=cpu_din`, `cpu_stall=1`.
  - On `mem_ack`: if the line is valid and the tag matches, line data ← `cpu_din`. On a miss the line is untouched (no allocate). Go to PARK.
- PARK (exactly one cycle):
  - `mem_cs=0`, `mem_we=0`, `mem_addr=PARK_ADDR`. This lets the RAM's stable-address counter restart and drop `ack` before the next access, including one to the same address.
  - `cpu_stall=0`. `cpu_dout` = response register for reads, 0 for writes.
  - Next state is IDLE.
- Counters saturate at 16'hFFFF.
- `mem_ack` is ignored in IDLE and PARK.

## Timing
- Reset (`rst=0`, asynchronous):
  - State goes to IDLE and every valid bit clears.
  - `mem_cs=0`, `mem_we=0`, `mem_addr=PARK_ADDR`, `mem_din=0`.
  - `hit_cnt=0`, `miss_cnt=0`, response register = 0, `cpu_stall=0`, `cpu_dout=0`.
- Reset mid-FILL/WRITE:
  - The transaction is abandoned and no line is written.
  - After release the CPU must re-present the request, which then misses.
- Read hit: zero stall cycles. `cpu_dout` is combinational from the line array.
- Miss or write latency = L + 1 stall cycles, where L is the cycles from FILL/WRITE entry until `mem_ack` is sampled high. Against `data_ram` (ack on the 9th negedge after the address changes), L = 9.
- `cpu_stall` is high from the request cycle through the last FILL/WRITE cycle. It is low in PARK.
- `mem_addr`, `mem_we` and `mem_din` are registered outputs and are constant throughout FILL/WRITE.
- The CPU holds `cpu_addr`, `cpu_we` and `cpu_din` stable while `cpu_stall=1`. The cache does not sample them again after IDLE.
- A request presented in PARK is not serviced until the following IDLE cycle. The CPU sees `cpu_stall=0` in PARK only for the completing access.

## Test plan
- Reset, then read addr 3 with RAM[3]=32'hDEAD_BEEF → 10 stall cycles, `cpu_dout`=32'hDEAD_BEEF in PARK, `miss_cnt`=1. An immediate re-read of 3 → no stall, same data, `hit_cnt`=1.
- Write 32'h1234_5678 to addr 3 (cached) → `mem_we=1` for the full handshake, 10 stall cycles. RAM[3] and the line both update, and the next read of 3 hits with 32'h1234_5678.
- Write to uncached addr 12 → RAM[12] updated and line 4 unchanged. A read of 12 then misses (`miss_cnt` increments).
- Read 2, then read 10 (same index 2, different tag) → both miss. Line 2 holds the data for 10, and a read of 2 misses again.
- Read addr 32'h0000_0040 (uncacheable) → `cpu_dout`=0, no stall, `mem_cs` stays 0, counters unchanged.
- Assert `rst=0` asynchronously in FILL cycle 4 → outputs take reset values immediately. After release, a read of the same address misses and completes correctly, which checks that the `mem_ack` restart works.
